// File: rtl/br_flag_unit_pkg.sv
// Shared types for the branch/flag unit: condition codes, FSM states, flag bit positions.
package br_flag_unit_pkg;

   // Branch condition encoding shared with the decoder
   typedef enum logic [2:0] {
      CcNeq    = 3'b000,
      CcEq     = 3'b001,
      CcGt     = 3'b010,
      CcLt     = 3'b011,
      CcGte    = 3'b100,
      CcLte    = 3'b101,
      CcOvfl   = 3'b110,
      CcUncond = 3'b111
   } br_cc_e;

   typedef enum logic {
      StIdle  = 1'b0,
      StFlush = 1'b1
   } br_state_e;

   // Bit positions inside the {Z,V,N} flag vector
   localparam int unsigned FlagZ = 2;
   localparam int unsigned FlagV = 1;
   localparam int unsigned FlagN = 0;

   // Flush countdown only needs to hold FLUSH_CYC-1, with FLUSH_CYC at most 3
   localparam int unsigned FlushCntW = 2;

endpackage

// File: rtl/br_flag_unit_flag_reg.sv
// Architectural Z/V/N register with the EX-stage bypass used by branch evaluation.
module br_flag_unit_flag_reg
   import br_flag_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       stall_i,
   input  logic       zr_i,
   input  logic       ov_i,
   input  logic       neg_i,
   input  logic       we_all_i,
   input  logic       we_zn_i,
   output logic [2:0] flags_o,
   output logic [2:0] eff_flags_o
);

   logic [2:0] flags_q, flags_d;
   logic [2:0] eff_flags;

   // Apply this cycle's update to the current register; we_all wins when both are set
   always_comb begin
      eff_flags = flags_q;
      if (we_all_i) begin
         eff_flags = {zr_i, ov_i, neg_i};
      end else if (we_zn_i) begin
         eff_flags[FlagZ] = zr_i;
         eff_flags[FlagN] = neg_i;
      end
      flags_d = stall_i ? flags_q : eff_flags;
   end

   // Flag register state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 3'b000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags_o     = flags_q;
   assign eff_flags_o = eff_flags;

endmodule

// File: rtl/br_flag_unit.sv
// Branch resolution against the ALU flags: condition mux, take/flush FSM, statistics.
module br_flag_unit
   import br_flag_unit_pkg::*;
#(
   parameter int unsigned FLUSH_CYC = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             zr,
   input  logic             ov,
   input  logic             neg,
   input  logic             flg_we_all,
   input  logic             flg_we_zn,
   input  logic             br_vld,
   input  logic [2:0]       br_cc,
   output logic             br_take,
   output logic             flush_IF_ID,
   output logic [2:0]       flags,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] ntaken_cnt
);

   localparam logic [FlushCntW-1:0] FlushInit = FlushCntW'(FLUSH_CYC - 1);

   logic [2:0]           eff_flags;
   logic                 cond_true;
   br_state_e            state_q, state_d;
   logic [FlushCntW-1:0] cnt_q, cnt_d;
   logic                 take_q, take_d;
   logic                 flush_q, flush_d;
   logic [CNT_W-1:0]     taken_q, taken_d;
   logic [CNT_W-1:0]     ntaken_q, ntaken_d;
   logic                 take_evt, ntake_evt;

   br_flag_unit_flag_reg u_flag_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_i     (stall),
      .zr_i        (zr),
      .ov_i        (ov),
      .neg_i       (neg),
      .we_all_i    (flg_we_all),
      .we_zn_i     (flg_we_zn),
      .flags_o     (flags),
      .eff_flags_o (eff_flags)
   );

   // Condition mux on the bypassed flags so a branch sees its predecessor's result
   always_comb begin
      cond_true = 1'b0;
      unique case (br_cc_e'(br_cc))
         CcNeq:    cond_true = !eff_flags[FlagZ];
         CcEq:     cond_true = eff_flags[FlagZ];
         CcGt:     cond_true = !eff_flags[FlagZ] && !eff_flags[FlagN];
         CcLt:     cond_true = eff_flags[FlagN];
         CcGte:    cond_true = !eff_flags[FlagN];
         CcLte:    cond_true = eff_flags[FlagN] || eff_flags[FlagZ];
         CcOvfl:   cond_true = eff_flags[FlagV];
         CcUncond: cond_true = 1'b1;
      endcase
   end

   // Next-state: branches are only evaluated in IDLE; FLUSH counts down wrong-path cycles
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      take_evt  = 1'b0;
      ntake_evt = 1'b0;
      if (!stall) begin
         unique case (state_q)
            StIdle: begin
               if (br_vld) begin
                  if (cond_true) begin
                     take_evt = 1'b1;
                     state_d  = StFlush;
                     cnt_d    = FlushInit;
                  end else begin
                     ntake_evt = 1'b1;
                  end
               end
            end
            StFlush: begin
               if (cnt_q == '0) begin
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         endcase
      end
   end

   // Registered outputs: take is a single pulse, flush lasts FLUSH_CYC cycles; both hold on stall
   always_comb begin
      take_d  = take_q;
      flush_d = flush_q;
      if (!stall) begin
         take_d  = take_evt;
         flush_d = take_evt || ((state_q == StFlush) && (cnt_q != '0));
      end
   end

   // Saturating statistics counters
   always_comb begin
      taken_d  = taken_q;
      ntaken_d = ntaken_q;
      if (take_evt && (taken_q != '1)) begin
         taken_d = taken_q + 1'b1;
      end
      if (ntake_evt && (ntaken_q != '1)) begin
         ntaken_d = ntaken_q + 1'b1;
      end
   end

   // State register for FSM, outputs and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         take_q   <= 1'b0;
         flush_q  <= 1'b0;
         taken_q  <= '0;
         ntaken_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         take_q   <= take_d;
         flush_q  <= flush_d;
         taken_q  <= taken_d;
         ntaken_q <= ntaken_d;
      end
   end

   assign br_take     = take_q;
   assign flush_IF_ID = flush_q;
   assign taken_cnt   = taken_q;
   assign ntaken_cnt  = ntaken_q;

endmodule

// File: tb/tb_br_flag_unit.sv
// Vector table plus hand sequences for br_flag_unit (FLUSH_CYC=3, CNT_W=4).
module tb_br_flag_unit;
   import br_flag_unit_pkg::*;

   typedef struct {
      logic       take;
      logic       flush;
      logic [2:0] flg;
      logic [3:0] tk;
      logic [3:0] nt;
   } exp_t;

   typedef struct {
      logic       st;
      logic       zr;
      logic       ov;
      logic       ng;
      logic       wa;
      logic       wz;
      logic       bv;
      logic [2:0] cc;
      exp_t       e;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       stall, zr, ov, neg, flg_we_all, flg_we_zn, br_vld;
   logic [2:0] br_cc;
   logic       br_take, flush_IF_ID;
   logic [2:0] flags;
   logic [3:0] taken_cnt, ntaken_cnt;

   int   total  = 0;
   int   passed = 0;
   exp_t sb[$];
   vec_t tbl[26];

   br_flag_unit #(
      .FLUSH_CYC (3),
      .CNT_W     (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .zr          (zr),
      .ov          (ov),
      .neg         (neg),
      .flg_we_all  (flg_we_all),
      .flg_we_zn   (flg_we_zn),
      .br_vld      (br_vld),
      .br_cc       (br_cc),
      .br_take     (br_take),
      .flush_IF_ID (flush_IF_ID),
      .flags       (flags),
      .taken_cnt   (taken_cnt),
      .ntaken_cnt  (ntaken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed++;
   endtask

   function automatic vec_t mk(input logic st, input logic z, input logic o, input logic n,
                               input logic wa, input logic wz, input logic bv,
                               input logic [2:0] cc, input logic tk_, input logic fl,
                               input logic [2:0] fg, input int t, input int c);
      vec_t v;
      v.st = st; v.zr = z; v.ov = o; v.ng = n; v.wa = wa; v.wz = wz; v.bv = bv; v.cc = cc;
      v.e.take = tk_; v.e.flush = fl; v.e.flg = fg; v.e.tk = 4'(t); v.e.nt = 4'(c);
      return v;
   endfunction

   // Drive at negedge, queue the expectation at the edge, compare at the next negedge
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      stall = v.st; zr = v.zr; ov = v.ov; neg = v.ng;
      flg_we_all = v.wa; flg_we_zn = v.wz; br_vld = v.bv; br_cc = v.cc;
      @(posedge clk);
      sb.push_back(v.e);
      @(negedge clk);
      if (sb.size() == 0) begin
         total++;
         $display("FAIL %s queue: got empty, expected an entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, " take"},  8'(br_take),     8'(e.take));
         chk({tag, " flush"}, 8'(flush_IF_ID), 8'(e.flush));
         chk({tag, " flags"}, 8'(flags),       8'(e.flg));
         chk({tag, " tk"},    8'(taken_cnt),   8'(e.tk));
         chk({tag, " nt"},    8'(ntaken_cnt),  8'(e.nt));
      end
   endtask

   task automatic drain(input logic [2:0] fg, input int t, input int c, input string tag);
      apply(mk(0, 0, 0, 0, 0, 0, 0, CcNeq, 0, 1, fg, t, c), {tag, "_d1"});
      apply(mk(0, 0, 0, 0, 0, 0, 0, CcNeq, 0, 1, fg, t, c), {tag, "_d2"});
      apply(mk(0, 0, 0, 0, 0, 0, 0, CcNeq, 0, 0, fg, t, c), {tag, "_d3"});
   endtask

   initial begin
      int e_tk;
      int e_nt;
      //              st zr ov ng wa wz bv cc        take fl flags   tk nt
      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 0, 3'b000, 0, 0);
      tbl[1]  = mk(0, 1, 0, 0, 1, 0, 1, CcEq,     1, 1, 3'b100, 1, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, CcUncond, 0, 1, 3'b100, 1, 0);
      tbl[3]  = mk(0, 0, 1, 0, 1, 0, 1, CcUncond, 0, 1, 3'b010, 1, 0);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, CcUncond, 0, 0, 3'b010, 1, 0);
      tbl[5]  = mk(0, 0, 0, 1, 0, 1, 1, CcOvfl,   1, 1, 3'b011, 2, 0);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 1, 3'b011, 2, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 1, 3'b011, 2, 0);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 0, 3'b011, 2, 0);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, CcGt,     0, 0, 3'b011, 2, 1);
      tbl[10] = mk(0, 0, 0, 0, 1, 0, 1, CcLt,     0, 0, 3'b000, 2, 2);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, CcNeq,    1, 1, 3'b000, 3, 2);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 1, 3'b000, 3, 2);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 1, 3'b000, 3, 2);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 0, 3'b000, 3, 2);
      tbl[15] = mk(0, 1, 0, 0, 0, 1, 1, CcLte,    1, 1, 3'b100, 4, 2);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 1, 3'b100, 4, 2);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 1, 3'b100, 4, 2);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 0, 3'b100, 4, 2);
      tbl[19] = mk(0, 0, 0, 1, 1, 0, 1, CcGte,    0, 0, 3'b001, 4, 3);
      tbl[20] = mk(0, 0, 1, 0, 1, 1, 1, CcOvfl,   1, 1, 3'b010, 5, 3);
      tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 1, 3'b010, 5, 3);
      tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 1, 3'b010, 5, 3);
      tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, CcNeq,    0, 0, 3'b010, 5, 3);
      tbl[24] = mk(1, 1, 0, 0, 1, 0, 1, CcUncond, 0, 0, 3'b010, 5, 3);
      tbl[25] = mk(0, 0, 0, 0, 0, 0, 1, CcEq,     0, 0, 3'b010, 5, 4);

      rst_n = 1'b0;
      stall = 0; zr = 0; ov = 0; neg = 0; flg_we_all = 0; flg_we_zn = 0; br_vld = 0;
      br_cc = 3'b000;
      #12;
      chk("rst take",  8'(br_take),     8'h0);
      chk("rst flush", 8'(flush_IF_ID), 8'h0);
      chk("rst flags", 8'(flags),       8'h0);
      chk("rst tk",    8'(taken_cnt),   8'h0);
      chk("rst nt",    8'(ntaken_cnt),  8'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 26; i++) apply(tbl[i], $sformatf("v%0d", i));

      // Stall right at the take pulse: pulse and counters freeze for two cycles
      apply(mk(0, 0, 0, 0, 0, 0, 1, CcUncond, 1, 1, 3'b010, 6, 4), "stl_take");
      for (int i = 0; i < 2; i++)
         apply(mk(1, 1, 0, 0, 1, 0, 1, CcUncond, 1, 1, 3'b010, 6, 4), $sformatf("stl%0d", i));
      drain(3'b010, 6, 4, "stl");

      // Not-taken counter saturation: LT with N=0
      e_nt = 4;
      for (int i = 0; i < 20; i++) begin
         e_nt = (e_nt < 15) ? e_nt + 1 : 15;
         apply(mk(0, 0, 0, 0, 0, 0, 1, CcLt, 0, 0, 3'b010, 6, e_nt), $sformatf("nsat%0d", i));
      end

      // Taken counter saturation
      e_tk = 6;
      for (int i = 0; i < 10; i++) begin
         e_tk = (e_tk < 15) ? e_tk + 1 : 15;
         apply(mk(0, 0, 0, 0, 0, 0, 1, CcUncond, 1, 1, 3'b010, e_tk, 15),
               $sformatf("tsat%0d", i));
         drain(3'b010, e_tk, 15, $sformatf("tsat%0d", i));
      end

      // Asynchronous reset in the middle of a flush
      apply(mk(0, 0, 0, 0, 0, 0, 1, CcUncond, 1, 1, 3'b010, 15, 15), "mrst_take");
      #2 rst_n = 1'b0;
      #1;
      chk("mrst take",  8'(br_take),     8'h0);
      chk("mrst flush", 8'(flush_IF_ID), 8'h0);
      chk("mrst flags", 8'(flags),       8'h0);
      chk("mrst tk",    8'(taken_cnt),   8'h0);
      chk("mrst nt",    8'(ntaken_cnt),  8'h0);
      @(negedge clk);
      rst_n = 1'b1;
      // Back in IDLE: an immediate branch is taken rather than ignored as wrong-path
      apply(mk(0, 0, 0, 0, 0, 0, 1, CcUncond, 1, 1, 3'b000, 1, 0), "post_rst");
      drain(3'b000, 1, 0, "post_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
